// File: rtl/rl_lj_force_accumulator_if.sv
// Stream interface of the LJ force accumulator: per-pair force words in,
// one summed force vector per reference particle out.
interface rl_lj_force_accumulator_if #(
  parameter int DATA_WIDTH         = 32,
  parameter int REF_RAM_ADDR_WIDTH = 7
);
  logic                          in_valid;
  logic [DATA_WIDTH-1:0]         in_force_x;
  logic [DATA_WIDTH-1:0]         in_force_y;
  logic [DATA_WIDTH-1:0]         in_force_z;
  logic                          out_valid;
  logic [REF_RAM_ADDR_WIDTH-1:0] out_ref_id;
  logic [DATA_WIDTH-1:0]         out_force_x;
  logic [DATA_WIDTH-1:0]         out_force_y;
  logic [DATA_WIDTH-1:0]         out_force_z;
  logic                          all_done;

  modport master (
    output in_valid, in_force_x, in_force_y, in_force_z,
    input  out_valid, out_ref_id, out_force_x, out_force_y, out_force_z, all_done
  );

  modport slave (
    input  in_valid, in_force_x, in_force_y, in_force_z,
    output out_valid, out_ref_id, out_force_x, out_force_y, out_force_z, all_done
  );
endinterface

// File: rtl/rl_lj_force_accumulator.sv
// Sums NEIGHBOR_PARTICLE_NUM pair forces per reference particle using ADD_LATENCY
// interleaved partial-sum lanes in two ping-pong banks, then reduces the idle bank.
module rl_lj_force_accumulator #(
  parameter int DATA_WIDTH            = 32,
  parameter int REF_PARTICLE_NUM      = 100,
  parameter int REF_RAM_ADDR_WIDTH    = 7,
  parameter int NEIGHBOR_PARTICLE_NUM = 100,
  parameter int ADD_LATENCY           = 4
) (
  input logic                       clk,
  input logic                       rst,
  rl_lj_force_accumulator_if.slave  acc_if
);

  localparam int L    = ADD_LATENCY;
  localparam int PD   = (L > 1) ? L - 1 : 1;
  localparam int LAST = PD - 1;
  localparam int NW   = $clog2(NEIGHBOR_PARTICLE_NUM);
  localparam int LW   = (L > 1) ? $clog2(L) : 1;
  localparam int IW   = $clog2(L + 1);
  localparam int RW   = REF_RAM_ADDR_WIDTH;

  typedef enum logic [1:0] {R_IDLE, R_DRAIN, R_ADD, R_EMIT} red_state_e;

  // Round-to-nearest-even single-precision add; subnormals flush to zero.
  function automatic logic [31:0] fp_add(input logic [31:0] a_in, input logic [31:0] b_in);
    logic [31:0] a, b;
    logic [23:0] ma, mb;
    logic [7:0]  d;
    logic [5:0]  dc, lz;
    logic [49:0] bfull, bsh;
    logic [50:0] sum;
    logic [9:0]  e;
    logic [24:0] mr;
    logic        found, zero, rnd, ovf;
    logic [31:0] res;
    if (a_in[30:0] >= b_in[30:0]) begin
      a = a_in;
      b = b_in;
    end else begin
      a = b_in;
      b = a_in;
    end
    ma    = (a[30:23] == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
    mb    = (b[30:23] == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
    d     = a[30:23] - b[30:23];
    dc    = (d > 8'd50) ? 6'd50 : d[5:0];
    bfull = {mb, 26'd0};
    bsh   = bfull >> dc;
    bsh[0] = bsh[0] | (|(bfull & ((50'd1 << dc) - 50'd1)));
    if (a[31] == b[31]) begin
      sum = {1'b0, ma, 26'd0} + {1'b0, bsh};
    end else begin
      sum = {1'b0, ma, 26'd0} - {1'b0, bsh};
    end
    zero  = (sum == 51'd0);
    e     = {2'b00, a[30:23]};
    lz    = 6'd0;
    found = 1'b0;
    if (sum[50]) begin
      sum = {1'b0, sum[50:2], sum[1] | sum[0]};
      e   = e + 10'd1;
    end else begin
      for (int i = 49; i >= 0; i--) begin
        found = found | sum[i];
        lz    = lz + {5'd0, ~found};
      end
      sum = sum << lz;
      e   = e - {4'd0, lz};
    end
    mr  = {1'b0, sum[49:26]};
    rnd = sum[25] & ((|sum[24:0]) | sum[26]);
    mr  = mr + {24'd0, rnd};
    ovf = mr[24];
    mr  = ovf ? (mr >> 1) : mr;
    e   = e + {9'd0, ovf};
    if (zero) begin
      res = 32'd0;
    end else if (e[9] || (e == 10'd0)) begin
      res = {a[31], 31'd0};
    end else if (e >= 10'd255) begin
      res = {a[31], 8'hFF, 23'd0};
    end else begin
      res = {a[31], e[7:0], mr[22:0]};
    end
    return res;
  endfunction

  logic [NW-1:0]         nbr_cnt_q;
  logic [LW-1:0]         lane_sel_q;
  logic                  bank_q;
  logic [DATA_WIDTH-1:0] lane_q [2][L][3];
  logic [DATA_WIDTH-1:0] pipe_q [PD][3];
  logic                  pipe_vld_q [PD];
  logic [LW-1:0]         pipe_lane_q [PD];
  logic                  pipe_bank_q [PD];

  red_state_e            state_q;
  logic                  red_bank_q;
  logic [IW-1:0]         red_i_q;
  logic [LW-1:0]         red_cnt_q;
  logic [DATA_WIDTH-1:0] acc_q [3];
  logic [DATA_WIDTH-1:0] red_pipe_q [PD][3];
  logic [RW-1:0]         ref_cnt_q;

  logic                  out_valid_q;
  logic                  all_done_q;
  logic [RW-1:0]         out_ref_id_q;
  logic [DATA_WIDTH-1:0] out_force_q [3];

  logic [DATA_WIDTH-1:0] in_f [3];
  logic [DATA_WIDTH-1:0] lane_sum_d [3];
  logic [DATA_WIDTH-1:0] red_sum_d [3];
  logic                  accept_s;
  logic                  last_in_s;

  assign in_f[0]   = acc_if.in_force_x;
  assign in_f[1]   = acc_if.in_force_y;
  assign in_f[2]   = acc_if.in_force_z;
  assign accept_s  = acc_if.in_valid;
  assign last_in_s = accept_s && (nbr_cnt_q == NW'(NEIGHBOR_PARTICLE_NUM - 1));

  assign acc_if.out_valid   = out_valid_q;
  assign acc_if.all_done    = all_done_q;
  assign acc_if.out_ref_id  = out_ref_id_q;
  assign acc_if.out_force_x = out_force_q[0];
  assign acc_if.out_force_y = out_force_q[1];
  assign acc_if.out_force_z = out_force_q[2];

  // Adder inputs: lane + incoming force, and running reduction + next lane.
  always_comb begin
    for (int ax = 0; ax < 3; ax++) begin
      lane_sum_d[ax] = fp_add(lane_q[bank_q][lane_sel_q][ax], in_f[ax]);
      red_sum_d[ax]  = fp_add(acc_q[ax], lane_q[red_bank_q][red_i_q[LW-1:0]][ax]);
    end
  end

  // Accumulation side: counters, tagged adder pipeline, lane writeback and bank clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      nbr_cnt_q  <= NW'(0);
      lane_sel_q <= LW'(0);
      bank_q     <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int l = 0; l < L; l++)
          for (int ax = 0; ax < 3; ax++)
            lane_q[b][l][ax] <= DATA_WIDTH'(0);
      for (int s = 0; s < PD; s++) begin
        pipe_vld_q[s]  <= 1'b0;
        pipe_lane_q[s] <= LW'(0);
        pipe_bank_q[s] <= 1'b0;
        for (int ax = 0; ax < 3; ax++) pipe_q[s][ax] <= DATA_WIDTH'(0);
      end
    end else begin
      pipe_vld_q[0]  <= accept_s;
      pipe_lane_q[0] <= lane_sel_q;
      pipe_bank_q[0] <= bank_q;
      for (int ax = 0; ax < 3; ax++) pipe_q[0][ax] <= lane_sum_d[ax];
      for (int s = 1; s < PD; s++) begin
        pipe_vld_q[s]  <= pipe_vld_q[s-1];
        pipe_lane_q[s] <= pipe_lane_q[s-1];
        pipe_bank_q[s] <= pipe_bank_q[s-1];
        for (int ax = 0; ax < 3; ax++) pipe_q[s][ax] <= pipe_q[s-1][ax];
      end
      if (state_q == R_EMIT) begin
        for (int l = 0; l < L; l++)
          for (int ax = 0; ax < 3; ax++)
            lane_q[red_bank_q][l][ax] <= DATA_WIDTH'(0);
      end
      // The lane register is the final adder stage, so a lane is current L cycles after issue.
      if (L == 1) begin
        if (accept_s) begin
          for (int ax = 0; ax < 3; ax++) lane_q[bank_q][lane_sel_q][ax] <= lane_sum_d[ax];
        end
      end else if (pipe_vld_q[LAST]) begin
        for (int ax = 0; ax < 3; ax++)
          lane_q[pipe_bank_q[LAST]][pipe_lane_q[LAST]][ax] <= pipe_q[LAST][ax];
      end
      if (accept_s) begin
        if (last_in_s) begin
          nbr_cnt_q  <= NW'(0);
          lane_sel_q <= LW'(0);
          bank_q     <= ~bank_q;
        end else begin
          nbr_cnt_q  <= nbr_cnt_q + NW'(1);
          lane_sel_q <= (lane_sel_q == LW'(L - 1)) ? LW'(0) : lane_sel_q + LW'(1);
        end
      end
    end
  end

  // Reduction FSM over the finished bank, with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= R_IDLE;
      red_bank_q   <= 1'b0;
      red_i_q      <= IW'(0);
      red_cnt_q    <= LW'(0);
      ref_cnt_q    <= RW'(0);
      out_valid_q  <= 1'b0;
      all_done_q   <= 1'b0;
      out_ref_id_q <= RW'(0);
      for (int ax = 0; ax < 3; ax++) begin
        acc_q[ax]       <= DATA_WIDTH'(0);
        out_force_q[ax] <= DATA_WIDTH'(0);
        for (int s = 0; s < PD; s++) red_pipe_q[s][ax] <= DATA_WIDTH'(0);
      end
    end else begin
      out_valid_q <= 1'b0;
      all_done_q  <= 1'b0;
      for (int ax = 0; ax < 3; ax++) begin
        red_pipe_q[0][ax] <= red_sum_d[ax];
        for (int s = 1; s < PD; s++) red_pipe_q[s][ax] <= red_pipe_q[s-1][ax];
      end
      case (state_q)
        R_IDLE: begin
          if (last_in_s) begin
            red_bank_q <= bank_q;
            red_cnt_q  <= LW'(0);
            state_q    <= R_DRAIN;
          end
        end
        R_DRAIN: begin
          if (red_cnt_q == LW'(L - 1)) begin
            for (int ax = 0; ax < 3; ax++) acc_q[ax] <= lane_q[red_bank_q][0][ax];
            red_i_q   <= IW'(1);
            red_cnt_q <= LW'(0);
            state_q   <= (L == 1) ? R_EMIT : R_ADD;
          end else begin
            red_cnt_q <= red_cnt_q + LW'(1);
          end
        end
        R_ADD: begin
          if (red_cnt_q == LW'(L - 1)) begin
            for (int ax = 0; ax < 3; ax++) acc_q[ax] <= red_pipe_q[LAST][ax];
            red_cnt_q <= LW'(0);
            red_i_q   <= red_i_q + IW'(1);
            if (red_i_q == IW'(L - 1)) state_q <= R_EMIT;
          end else begin
            red_cnt_q <= red_cnt_q + LW'(1);
          end
        end
        R_EMIT: begin
          for (int ax = 0; ax < 3; ax++) out_force_q[ax] <= acc_q[ax];
          out_ref_id_q <= ref_cnt_q;
          out_valid_q  <= 1'b1;
          all_done_q   <= (ref_cnt_q == RW'(REF_PARTICLE_NUM - 1));
          ref_cnt_q    <= (ref_cnt_q == RW'(REF_PARTICLE_NUM - 1)) ? RW'(0) : ref_cnt_q + RW'(1);
          state_q      <= R_IDLE;
        end
        default: state_q <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rl_lj_force_accumulator.sv
// Directed bench: default accumulator, a 3-particle/N=20 instance and an
// ADD_LATENCY=1/N=4 instance, with hand-computed IEEE-754 sums.
module tb_rl_lj_force_accumulator;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rl_lj_force_accumulator_if #(.DATA_WIDTH(32), .REF_RAM_ADDR_WIDTH(7)) if0 ();
  rl_lj_force_accumulator_if #(.DATA_WIDTH(32), .REF_RAM_ADDR_WIDTH(7)) if1 ();
  rl_lj_force_accumulator_if #(.DATA_WIDTH(32), .REF_RAM_ADDR_WIDTH(7)) if2 ();

  rl_lj_force_accumulator u_dut (.clk(clk), .rst(rst), .acc_if(if0));

  rl_lj_force_accumulator #(.REF_PARTICLE_NUM(3), .NEIGHBOR_PARTICLE_NUM(20))
    u_dut_small (.clk(clk), .rst(rst), .acc_if(if1));

  rl_lj_force_accumulator #(.NEIGHBOR_PARTICLE_NUM(4), .ADD_LATENCY(1))
    u_dut_l1 (.clk(clk), .rst(rst), .acc_if(if2));

  typedef struct {
    int          cyc;
    logic [6:0]  id;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic        done;
  } emit_t;

  emit_t q0[$];
  emit_t q1[$];
  emit_t q2[$];
  emit_t mon_e;

  always @(negedge clk) begin
    if (if0.out_valid === 1'b1) begin
      mon_e.cyc = cyc; mon_e.id = if0.out_ref_id; mon_e.done = if0.all_done;
      mon_e.x = if0.out_force_x; mon_e.y = if0.out_force_y; mon_e.z = if0.out_force_z;
      q0.push_back(mon_e);
    end
    if (if1.out_valid === 1'b1) begin
      mon_e.cyc = cyc; mon_e.id = if1.out_ref_id; mon_e.done = if1.all_done;
      mon_e.x = if1.out_force_x; mon_e.y = if1.out_force_y; mon_e.z = if1.out_force_z;
      q1.push_back(mon_e);
    end
    if (if2.out_valid === 1'b1) begin
      mon_e.cyc = cyc; mon_e.id = if2.out_ref_id; mon_e.done = if2.all_done;
      mon_e.x = if2.out_force_x; mon_e.y = if2.out_force_y; mon_e.z = if2.out_force_z;
      q2.push_back(mon_e);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int sel, input logic v, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] z);
    case (sel)
      0: begin if0.in_valid = v; if0.in_force_x = x; if0.in_force_y = y; if0.in_force_z = z; end
      1: begin if1.in_valid = v; if1.in_force_x = x; if1.in_force_y = y; if1.in_force_z = z; end
      default: begin if2.in_valid = v; if2.in_force_x = x; if2.in_force_y = y; if2.in_force_z = z; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves in_valid high after the last input so consecutive calls stream back-to-back.
  task automatic feed(input int sel, input int n, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] z, input int gap, output int last);
    last = 0;
    for (int i = 0; i < n; i++) begin
      drv(sel, 1'b1, x, y, z);
      tick();
      last = cyc;
      if (gap > 0) begin
        drv(sel, 1'b0, x, y, z);
        repeat (gap) tick();
      end
    end
  endtask

  function automatic int qsize(input int sel);
    case (sel)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic emit_t qget(input int sel, input int i);
    case (sel)
      0:       return q0[i];
      1:       return q1[i];
      default: return q2[i];
    endcase
  endfunction

  task automatic wait_q(input int sel, input int n, input int budget);
    int k;
    k = 0;
    while ((qsize(sel) < n) && (k < budget)) begin
      tick();
      k++;
    end
    chk("emit_count", 32'(qsize(sel)), 32'(n));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int    last, last1, last2;
    emit_t e;

    rst = 1'b0;
    drv(0, 1'b0, 32'h0, 32'h0, 32'h0);
    drv(1, 1'b0, 32'h0, 32'h0, 32'h0);
    drv(2, 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (3) tick();
    chk("rst_out_valid", 32'(if0.out_valid), 32'h0);
    chk("rst_all_done", 32'(if0.all_done), 32'h0);
    chk("rst_ref_id", 32'(if0.out_ref_id), 32'h0);
    chk("rst_fx", if0.out_force_x, 32'h0);
    chk("rst_fy", if0.out_force_y, 32'h0);
    chk("rst_fz", if0.out_force_z, 32'h0);
    rst = 1'b1;
    tick();

    // Contiguous particle
    feed(0, 100, 32'h3F800000, 32'h40000000, 32'hBF800000, 0, last);
    drv(0, 1'b0, 32'h0, 32'h0, 32'h0);
    wait_q(0, 1, 40);
    e = qget(0, 0);
    chk("contig_fx", e.x, 32'h42C80000);
    chk("contig_fy", e.y, 32'h43480000);
    chk("contig_fz", e.z, 32'hC2C80000);
    chk("contig_id", 32'(e.id), 32'd0);
    chk("contig_done", 32'(e.done), 32'd0);
    chk("contig_latency", 32'(e.cyc - last), 32'd17);
    tick();
    chk("pulse_low", 32'(if0.out_valid), 32'h0);
    chk("hold_fx", if0.out_force_x, 32'h42C80000);

    // Every third cycle valid
    q0.delete();
    feed(0, 100, 32'h3F800000, 32'h40000000, 32'hBF800000, 2, last);
    wait_q(0, 1, 40);
    e = qget(0, 0);
    chk("gap_fx", e.x, 32'h42C80000);
    chk("gap_fy", e.y, 32'h43480000);
    chk("gap_fz", e.z, 32'hC2C80000);
    chk("gap_id", 32'(e.id), 32'd1);
    chk("gap_latency", 32'(e.cyc - last), 32'd17);

    // Two particles back-to-back after a reset
    do_reset();
    q0.delete();
    feed(0, 100, 32'h3F800000, 32'h40000000, 32'hBF800000, 0, last1);
    feed(0, 100, 32'h3F000000, 32'h3F000000, 32'h3F000000, 0, last2);
    drv(0, 1'b0, 32'h0, 32'h0, 32'h0);
    wait_q(0, 2, 60);
    e = qget(0, 0);
    chk("b2b0_fx", e.x, 32'h42C80000);
    chk("b2b0_fy", e.y, 32'h43480000);
    chk("b2b0_fz", e.z, 32'hC2C80000);
    chk("b2b0_id", 32'(e.id), 32'd0);
    chk("b2b0_latency", 32'(e.cyc - last1), 32'd17);
    e = qget(0, 1);
    chk("b2b1_fx", e.x, 32'h42480000);
    chk("b2b1_fy", e.y, 32'h42480000);
    chk("b2b1_fz", e.z, 32'h42480000);
    chk("b2b1_id", 32'(e.id), 32'd1);
    chk("b2b1_latency", 32'(e.cyc - last2), 32'd17);

    // Reset in the middle of a particle
    q0.delete();
    feed(0, 50, 32'h3F800000, 32'h3F800000, 32'h3F800000, 0, last);
    drv(0, 1'b0, 32'h0, 32'h0, 32'h0);
    do_reset();
    repeat (30) tick();
    chk("midrst_no_emit", 32'(qsize(0)), 32'd0);
    chk("midrst_out_valid", 32'(if0.out_valid), 32'h0);
    chk("midrst_ref_id", 32'(if0.out_ref_id), 32'h0);
    chk("midrst_fx", if0.out_force_x, 32'h0);
    chk("midrst_fy", if0.out_force_y, 32'h0);
    chk("midrst_fz", if0.out_force_z, 32'h0);
    feed(0, 100, 32'h3F800000, 32'h3F800000, 32'h3F800000, 0, last);
    drv(0, 1'b0, 32'h0, 32'h0, 32'h0);
    wait_q(0, 1, 40);
    repeat (20) tick();
    chk("midrst_single_emit", 32'(qsize(0)), 32'd1);
    e = qget(0, 0);
    chk("midrst_fx_sum", e.x, 32'h42C80000);
    chk("midrst_id", 32'(e.id), 32'd0);

    // Small instance: id wrap and all_done
    feed(1, 80, 32'h3F800000, 32'h3F800000, 32'h3F800000, 0, last);
    drv(1, 1'b0, 32'h0, 32'h0, 32'h0);
    wait_q(1, 4, 60);
    for (int k = 0; k < 4; k++) begin
      e = qget(1, k);
      chk("small_fx", e.x, 32'h41A00000);
      chk("small_id", 32'(e.id), 32'(k % 3));
      chk("small_done", 32'(e.done), 32'(k == 2));
    end

    // Single-lane instance
    feed(2, 1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 0, last);
    feed(2, 1, 32'h40000000, 32'h40000000, 32'h40000000, 0, last);
    feed(2, 1, 32'h40800000, 32'h40800000, 32'h40800000, 0, last);
    feed(2, 1, 32'h41000000, 32'h41000000, 32'h41000000, 0, last);
    drv(2, 1'b0, 32'h0, 32'h0, 32'h0);
    wait_q(2, 1, 20);
    e = qget(2, 0);
    chk("l1_fx", e.x, 32'h41700000);
    chk("l1_id", 32'(e.id), 32'd0);
    chk("l1_latency", 32'(e.cyc - last), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
